// File: rtl/dotprod_pkg.sv
// Shared definitions for the dot-product engine: CSR word offsets, MODE bits, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dotprod_pkg;

  localparam logic [2:0] CSR_START  = 3'd0;
  localparam logic [2:0] CSR_BIAS   = 3'd1;
  localparam logic [2:0] CSR_W_ADDR = 3'd2;
  localparam logic [2:0] CSR_A_ADDR = 3'd3;
  localparam logic [2:0] CSR_LEN    = 3'd4;
  localparam logic [2:0] CSR_MODE   = 3'd5;
  localparam logic [2:0] CSR_STATUS = 3'd6;

  localparam int MODE_RELU = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ_W,
    S_WAIT_W,
    S_REQ_A,
    S_WAIT_A,
    S_MAC,
    S_DONE
  } state_t;

endpackage

// File: rtl/dotprod_accel_fxp_mac.sv
// Fixed-point MAC: acc += (w*a)>>>FRAC_W; result = sat(relu(acc + bias)).
// Latency: accumulator updates on the clock after en_i; res_o is combinational from acc.
// Backpressure: none, the caller sequences clr_i/en_i.
// Ports: clk/rst_n; clr_i zeroes acc; en_i accumulates w_i*a_i; bias_i/relu_i shape res_o.
module fxp_mac #(
  parameter int DATA_W = 32,
  parameter int FRAC_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr_i,
  input  logic                     en_i,
  input  logic signed [DATA_W-1:0] w_i,
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [DATA_W-1:0] bias_i,
  input  logic                     relu_i,
  output logic signed [DATA_W-1:0] res_o
);

  localparam int ACC_W = 2 * DATA_W;
  localparam logic signed [ACC_W-1:0] SAT_MAX = (ACC_W'(1) << (DATA_W - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -(ACC_W'(1) << (DATA_W - 1));

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] prod, prod_sh, sum;

  always_comb begin
    prod    = w_i * a_i;
    // Arithmetic shift re-aligns the Q(2F) product back to Q(F).
    prod_sh = prod >>> FRAC_W;
    acc_d   = acc_q;
    if (clr_i)     acc_d = '0;
    else if (en_i) acc_d = acc_q + prod_sh;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  always_comb begin
    sum = acc_q + {{DATA_W{bias_i[DATA_W-1]}}, bias_i};
    if (relu_i && sum[ACC_W-1]) sum = '0;
    if (sum > SAT_MAX)      res_o = SAT_MAX[DATA_W-1:0];
    else if (sum < SAT_MIN) res_o = SAT_MIN[DATA_W-1:0];
    else                    res_o = sum[DATA_W-1:0];
  end

endmodule

// File: rtl/dotprod_accel.sv
// Dot-product engine: CSR slave + single-outstanding read master feeding a fixed-point MAC.
// Latency: 5 cycles per element with zero-wait memory, plus START and DONE cycles.
// Backpressure: master stalls on master_waitrequest; offset-0 slave access waits while busy.
// Ports: clk/rst_n; slave_* Avalon-MM CSR port (readdata latency 0); master_* Avalon-MM read port.
module dotprod_accel
  import dotprod_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int FRAC_W = 16,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              slave_waitrequest,
  input  logic [2:0]        slave_address,
  input  logic              slave_read,
  input  logic              slave_write,
  input  logic [DATA_W-1:0] slave_writedata,
  output logic [DATA_W-1:0] slave_readdata,
  input  logic              master_waitrequest,
  output logic [ADDR_W-1:0] master_address,
  output logic              master_read,
  input  logic [DATA_W-1:0] master_readdata,
  input  logic              master_readdatavalid
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(DATA_W / 8);

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   bias_q, bias_d, bias_w_q, bias_w_d, result_q, result_d;
  logic [ADDR_W-1:0]   w_addr_q, w_addr_d, a_addr_q, a_addr_d;
  logic [ADDR_W-1:0]   w_ptr_q, w_ptr_d, a_ptr_q, a_ptr_d;
  logic [LEN_W-1:0]    len_q, len_d, cnt_q, cnt_d;
  logic                relu_q, relu_d;
  logic [DATA_W-1:0]   w_dat_q, w_dat_d, a_dat_q, a_dat_d;
  logic                busy, acc_clr, acc_en;
  logic [DATA_W-1:0]   mac_res;

  assign busy = (state_q != S_IDLE);

  // Only offset 0 ever stalls; it is held until the engine is back in IDLE.
  assign slave_waitrequest = (slave_read || slave_write) && (slave_address == CSR_START) && busy;

  assign master_read    = (state_q == S_REQ_W) || (state_q == S_REQ_A);
  assign master_address = (state_q == S_REQ_A) ? a_ptr_q : w_ptr_q;

  always_comb begin
    slave_readdata = '0;
    if (slave_read) begin
      case (slave_address)
        CSR_START:  slave_readdata = result_q;
        CSR_BIAS:   slave_readdata = bias_q;
        CSR_W_ADDR: slave_readdata = DATA_W'(w_addr_q);
        CSR_A_ADDR: slave_readdata = DATA_W'(a_addr_q);
        CSR_LEN:    slave_readdata = DATA_W'(len_q);
        CSR_MODE:   slave_readdata[MODE_RELU] = relu_q;
        CSR_STATUS: slave_readdata[0] = busy;
        default:    slave_readdata = '0;
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    bias_d   = bias_q;
    w_addr_d = w_addr_q;
    a_addr_d = a_addr_q;
    len_d    = len_q;
    relu_d   = relu_q;
    result_d = result_q;
    bias_w_d = bias_w_q;
    w_ptr_d  = w_ptr_q;
    a_ptr_d  = a_ptr_q;
    cnt_d    = cnt_q;
    w_dat_d  = w_dat_q;
    a_dat_d  = a_dat_q;
    acc_clr  = 1'b0;
    acc_en   = 1'b0;

    // Configuration is frozen while a computation is running.
    if (slave_write && !busy) begin
      case (slave_address)
        CSR_BIAS:   bias_d   = slave_writedata;
        CSR_W_ADDR: w_addr_d = ADDR_W'(slave_writedata);
        CSR_A_ADDR: a_addr_d = ADDR_W'(slave_writedata);
        CSR_LEN:    len_d    = LEN_W'(slave_writedata);
        CSR_MODE:   relu_d   = slave_writedata[MODE_RELU];
        default:    ;
      endcase
    end

    case (state_q)
      S_IDLE: begin
        if (slave_write && slave_address == CSR_START) begin
          w_ptr_d  = w_addr_q;
          a_ptr_d  = a_addr_q;
          cnt_d    = len_q;
          bias_w_d = bias_q;
          acc_clr  = 1'b1;
          state_d  = (len_q == '0) ? S_DONE : S_REQ_W;
        end
      end
      S_REQ_W:  if (!master_waitrequest) state_d = S_WAIT_W;
      S_WAIT_W: if (master_readdatavalid) begin
        w_dat_d = master_readdata;
        state_d = S_REQ_A;
      end
      S_REQ_A:  if (!master_waitrequest) state_d = S_WAIT_A;
      S_WAIT_A: if (master_readdatavalid) begin
        a_dat_d = master_readdata;
        state_d = S_MAC;
      end
      S_MAC: begin
        acc_en  = 1'b1;
        w_ptr_d = w_ptr_q + STEP;
        a_ptr_d = a_ptr_q + STEP;
        cnt_d   = cnt_q - LEN_W'(1);
        state_d = (cnt_d == '0) ? S_DONE : S_REQ_W;
      end
      S_DONE: begin
        result_d = mac_res;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      bias_q   <= '0;
      w_addr_q <= '0;
      a_addr_q <= '0;
      len_q    <= '0;
      relu_q   <= 1'b0;
      result_q <= '0;
      bias_w_q <= '0;
      w_ptr_q  <= '0;
      a_ptr_q  <= '0;
      cnt_q    <= '0;
      w_dat_q  <= '0;
      a_dat_q  <= '0;
    end else begin
      state_q  <= state_d;
      bias_q   <= bias_d;
      w_addr_q <= w_addr_d;
      a_addr_q <= a_addr_d;
      len_q    <= len_d;
      relu_q   <= relu_d;
      result_q <= result_d;
      bias_w_q <= bias_w_d;
      w_ptr_q  <= w_ptr_d;
      a_ptr_q  <= a_ptr_d;
      cnt_q    <= cnt_d;
      w_dat_q  <= w_dat_d;
      a_dat_q  <= a_dat_d;
    end
  end

  fxp_mac #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W)
  ) u_mac (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (acc_clr),
    .en_i   (acc_en),
    .w_i    (w_dat_q),
    .a_i    (a_dat_q),
    .bias_i (bias_w_q),
    .relu_i (relu_q),
    .res_o  (mac_res)
  );

endmodule

// File: tb/tb_dotprod_accel.sv
// Testbench for dotprod_accel: directed vectors, slave-read scoreboard, randomised memory model.
// Latency: n/a.
// Backpressure: memory model injects command stalls and readdatavalid delay.
module tb_dotprod_accel;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        slave_waitrequest;
  logic [2:0]  slave_address = '0;
  logic        slave_read = 1'b0;
  logic        slave_write = 1'b0;
  logic [31:0] slave_writedata = '0;
  logic [31:0] slave_readdata;
  logic        master_waitrequest;
  logic [31:0] master_address;
  logic        master_read;
  logic [31:0] master_readdata;
  logic        master_readdatavalid;

  dotprod_accel dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .slave_waitrequest    (slave_waitrequest),
    .slave_address        (slave_address),
    .slave_read           (slave_read),
    .slave_write          (slave_write),
    .slave_writedata      (slave_writedata),
    .slave_readdata       (slave_readdata),
    .master_waitrequest   (master_waitrequest),
    .master_address       (master_address),
    .master_read          (master_read),
    .master_readdata      (master_readdata),
    .master_readdatavalid (master_readdatavalid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  // ---------------- memory model ----------------
  logic [31:0] mem [0:255];
  int          max_stall = 0, min_dly = 1, max_dly = 1;
  int          n_reads = 0;
  logic [31:0] addr_log[$];

  initial begin
    bit          pend = 0, armed = 0, prev_stalled = 0;
    int          pend_cnt = 0, stall_left = 0;
    logic [31:0] pend_dat = '0, prev_addr = '0;
    master_waitrequest   = 1'b0;
    master_readdatavalid = 1'b0;
    master_readdata      = '0;
    forever begin
      @(posedge clk); #1;
      master_readdatavalid = 1'b0;
      if (pend) begin
        if (pend_cnt == 0) begin
          master_readdatavalid = 1'b1;
          master_readdata      = pend_dat;
          pend                 = 0;
        end else pend_cnt--;
      end
      if (prev_stalled) check("cmd_hold", {master_read, master_address}, {1'b1, prev_addr});
      prev_stalled = 0;
      master_waitrequest = 1'b0;
      if (master_read) begin
        if (!armed) begin
          stall_left = $urandom_range(max_stall, 0);
          armed = 1;
        end
        if (stall_left > 0) begin
          master_waitrequest = 1'b1;
          stall_left--;
          prev_stalled = 1;
          prev_addr    = master_address;
        end else begin
          armed    = 0;
          pend     = 1;
          pend_dat = mem[master_address[9:2]];
          pend_cnt = $urandom_range(max_dly, min_dly) - 1;
          n_reads++;
          addr_log.push_back(master_address);
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  string       nm_q[$];

  always @(negedge clk) begin
    if (rst_n && slave_read && !slave_waitrequest) begin
      if (exp_q.size() == 0) check("sb_unexpected_read", 64'(exp_q.size()), 64'd1);
      else check(nm_q.pop_front(), slave_readdata, exp_q.pop_front());
    end
  end

  task automatic bus(input bit wr, input logic [2:0] addr, input logic [31:0] dat, input string nm);
    int n = 0;
    @(posedge clk); #1;
    slave_address   = addr;
    slave_write     = wr;
    slave_read      = !wr;
    slave_writedata = dat;
    @(negedge clk);
    while (slave_waitrequest && n < 400) begin
      n++;
      @(negedge clk);
    end
    if (slave_waitrequest) check({nm, "_timeout"}, slave_waitrequest, 1'b0);
    @(posedge clk); #1;
    slave_write = 1'b0;
    slave_read  = 1'b0;
  endtask

  task automatic csr_wr(input logic [2:0] addr, input logic [31:0] dat);
    bus(1'b1, addr, dat, "write");
  endtask

  task automatic csr_rd(input logic [2:0] addr, input logic [31:0] exp, input string nm);
    exp_q.push_back(exp);
    nm_q.push_back(nm);
    bus(1'b0, addr, '0, nm);
  endtask

  task automatic setup(input logic [31:0] bias, input logic [31:0] len, input logic [31:0] mode);
    csr_wr(3'd1, bias);
    csr_wr(3'd2, 32'h100);
    csr_wr(3'd3, 32'h200);
    csr_wr(3'd4, len);
    csr_wr(3'd5, mode);
  endtask

  task automatic set_vec(input logic [31:0] w0, w1, w2, a0, a1, a2);
    mem[64] = w0; mem[65] = w1; mem[66] = w2;
    mem[128] = a0; mem[129] = a1; mem[130] = a2;
  endtask

  // Start, then a read of offset 0 that stalls until the result is ready.
  task automatic run(input logic [31:0] exp, input string nm, input int exp_cyc);
    int t0;
    csr_wr(3'd0, 32'h0);
    t0 = cyc;
    csr_rd(3'd0, exp, nm);
    if (exp_cyc > 0) check({nm, "_cycles"}, 64'(cyc - t0), 64'(exp_cyc));
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, t0, k;
    for (int i = 0; i < 256; i++) mem[i] = '0;

    // Reset values
    #12;
    check("rst_master_read", master_read, 1'b0);
    check("rst_master_addr", master_address, 32'h0);
    check("rst_waitrequest", slave_waitrequest, 1'b0);
    check("rst_readdata", slave_readdata, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    csr_rd(3'd0, 32'h0, "rst_result");
    csr_rd(3'd1, 32'h0, "rst_bias");
    csr_rd(3'd4, 32'h0, "rst_len");
    csr_rd(3'd6, 32'h0, "rst_status");
    csr_rd(3'd7, 32'h0, "rst_reserved");

    // Basic: 1*3 + 2*0.5 - 0.5*4 + 0.25 = 2.25
    set_vec(32'h0001_0000, 32'h0002_0000, 32'hFFFF_8000, 32'h0003_0000, 32'h0000_8000, 32'h0004_0000);
    setup(32'h0000_4000, 32'd3, 32'd0);
    csr_rd(3'd2, 32'h100, "w_addr_rb");
    csr_rd(3'd4, 32'd3, "len_rb");
    csr_wr(3'd7, 32'hDEAD_BEEF);
    csr_rd(3'd7, 32'h0, "reserved_rb");
    r0 = n_reads;
    addr_log.delete();
    csr_wr(3'd0, 32'h0);
    check("start_master_read", master_read, 1'b1);
    t0 = cyc;
    csr_rd(3'd0, 32'h0002_4000, "basic_result");
    check("basic_cycles", 64'(cyc - t0), 64'd17);
    check("basic_nreads", 64'(n_reads - r0), 64'd6);
    for (int i = 0; i < 6; i++) begin
      logic [31:0] ea;
      ea = ((i % 2) ? 32'h200 : 32'h100) + 32'(4 * (i / 2));
      check("basic_addr", (i < addr_log.size()) ? addr_log[i] : 32'hFFFF_FFFF, ea);
    end

    // ReLU: 2.0 - 4.0 = -2.0
    setup(32'hFFFC_0000, 32'd3, 32'd0);
    run(32'hFFFE_0000, "relu_off", 17);
    csr_wr(3'd5, 32'd1);
    csr_rd(3'd5, 32'd1, "mode_rb");
    csr_wr(3'd0, 32'h0);
    csr_rd(3'd6, 32'd1, "status_busy");
    csr_wr(3'd1, 32'h1234_5678);
    csr_rd(3'd1, 32'hFFFC_0000, "bias_frozen");
    csr_rd(3'd0, 32'h0, "relu_on");

    // Saturation both ways
    set_vec(32'h7FFF_0000, 32'h7FFF_0000, 32'h0, 32'h0002_0000, 32'h0002_0000, 32'h0);
    setup(32'h0, 32'd2, 32'd0);
    run(32'h7FFF_FFFF, "sat_pos", 12);
    set_vec(32'h8001_0000, 32'h8001_0000, 32'h0, 32'h0002_0000, 32'h0002_0000, 32'h0);
    run(32'h8000_0000, "sat_neg", 12);

    // LEN=0: bias passes straight through, no memory traffic
    setup(32'hFFFE_8000, 32'd0, 32'd0);
    r0 = n_reads;
    run(32'hFFFE_8000, "len0", 2);
    check("len0_nreads", 64'(n_reads - r0), 64'd0);

    // Backpressure, plus a stalled START write accepted after DONE
    set_vec(32'h0001_0000, 32'h0002_0000, 32'hFFFF_8000, 32'h0003_0000, 32'h0000_8000, 32'h0004_0000);
    setup(32'h0000_4000, 32'd3, 32'd0);
    max_stall = 3; min_dly = 1; max_dly = 4;
    r0 = n_reads;
    csr_wr(3'd0, 32'h0);
    csr_wr(3'd0, 32'h0);
    csr_rd(3'd0, 32'h0002_4000, "bp_result");
    check("bp_nreads", 64'(n_reads - r0), 64'd12);

    // Reset while waiting for A of element 2, then a stray readdatavalid
    max_stall = 0; min_dly = 4; max_dly = 4;
    r0 = n_reads;
    csr_wr(3'd0, 32'h0);
    k = 0;
    while (n_reads - r0 < 4 && k < 200) begin
      k++;
      @(posedge clk);
    end
    check("rst_wait_reads", 64'(n_reads - r0), 64'd4);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("arst_master_read", master_read, 1'b0);
    check("arst_master_addr", master_address, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("arst_no_reads", 64'(n_reads - r0), 64'd4);
    csr_rd(3'd6, 32'h0, "arst_status");
    csr_rd(3'd0, 32'h0, "arst_result");
    repeat (3) @(posedge clk);
    check("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
